// File: rtl/uctl_tx_pkt_drain_if.sv
// ---------------------------------------------------------------------------
// uctl_tx_pkt_drain_if
//   Bus bundle between the endpoint TX FIFO / packet control, the drain block
//   and the USB TX data-phase encoder.
//
//   Signals:
//     pkt_start, pkt_len           packet command (pkt_len sampled with pkt_start)
//     fifo_empty, fifo_dataOut,    FIFO status and fall-through head word
//     fifo_numOfData, fifo_rdEn    FIFO word count (status only) and pop strobe
//     tx_valid, tx_data, tx_last,  byte stream towards the encoder
//     tx_ready
//     tx_zlp, pkt_done, busy,      packet status
//     tx_abort
//
//   Modports:
//     slave  - the drain block (consumes commands/FIFO, drives the byte stream)
//     master - the environment (FIFO, encoder, packet control)
// ---------------------------------------------------------------------------
interface uctl_tx_pkt_drain_if #(
   parameter int ADD_WIDTH = 4,
   parameter int LEN_WIDTH = 11
);
   logic                 pkt_start;
   logic [LEN_WIDTH-1:0] pkt_len;
   logic                 fifo_empty;
   logic [31:0]          fifo_dataOut;
   logic [ADD_WIDTH:0]   fifo_numOfData;
   logic                 fifo_rdEn;
   logic                 tx_valid;
   logic [7:0]           tx_data;
   logic                 tx_last;
   logic                 tx_ready;
   logic                 tx_zlp;
   logic                 pkt_done;
   logic                 busy;
   logic                 tx_abort;

   modport slave (
      input  pkt_start, pkt_len, fifo_empty, fifo_dataOut, fifo_numOfData, tx_ready,
      output fifo_rdEn, tx_valid, tx_data, tx_last, tx_zlp, pkt_done, busy, tx_abort
   );

   modport master (
      output pkt_start, pkt_len, fifo_empty, fifo_dataOut, fifo_numOfData, tx_ready,
      input  fifo_rdEn, tx_valid, tx_data, tx_last, tx_zlp, pkt_done, busy, tx_abort
   );
endinterface

// File: rtl/uctl_tx_pkt_drain.sv
// ---------------------------------------------------------------------------
// uctl_tx_pkt_drain
//   Drains a packet of pkt_len bytes from the 32-bit endpoint TX FIFO and
//   serialises it little-endian into an 8-bit valid/ready byte stream for the
//   USB TX encoder. Whole words are popped; unused upper bytes of the last
//   word are discarded. pkt_len==0 produces a single tx_zlp pulse instead.
//
//   Ports:
//     clk     system clock
//     rst_n   asynchronous active-low reset
//     sw_rst  synchronous soft reset (active high, overrides everything)
//     bus     uctl_tx_pkt_drain_if.slave (command, FIFO, byte stream, status)
//
//   Optional feature (compile-time macro UCTL_TX_UNDERRUN_ABORT_EN):
//     when defined, UNDERRUN_TO consecutive FIFO-empty cycles while waiting
//     for the next word abort the packet with a tx_abort pulse. When not
//     defined, the block waits for data indefinitely and tx_abort is 0.
// ---------------------------------------------------------------------------
module uctl_tx_pkt_drain #(
   parameter int ADD_WIDTH   = 4,
   parameter int LEN_WIDTH   = 11,
   parameter int UNDERRUN_TO = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sw_rst,
   uctl_tx_pkt_drain_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [LEN_WIDTH-1:0] REM_ONE = LEN_WIDTH'(1);

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] rem_q, rem_d;
   logic [1:0]           idx_q, idx_d;
   logic [31:0]          word_q, word_d;
   logic                 zlp_q, zlp_d;

   // Word count is status only; flow control uses fifo_empty.
   logic [ADD_WIDTH:0]   unused_level;
   assign unused_level = bus.fifo_numOfData;

`ifdef UCTL_TX_UNDERRUN_ABORT_EN
   localparam int                 STALL_W    = $clog2(UNDERRUN_TO + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(UNDERRUN_TO - 1);
   localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

   logic [STALL_W-1:0] stall_q, stall_d;
`else
   logic [31:0] unused_to;
   assign unused_to = UNDERRUN_TO;
`endif

   assign bus.busy   = (state_q != IDLE);
   assign bus.tx_zlp = zlp_q;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      idx_d   = idx_q;
      word_d  = word_q;
      zlp_d   = 1'b0;
`ifdef UCTL_TX_UNDERRUN_ABORT_EN
      stall_d = stall_q;
`endif
      bus.fifo_rdEn = 1'b0;
      bus.tx_valid  = 1'b0;
      bus.tx_data   = '0;
      bus.tx_last   = 1'b0;
      bus.pkt_done  = 1'b0;
      bus.tx_abort  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.pkt_start) begin
               if (bus.pkt_len == '0) begin
                  zlp_d = 1'b1;
               end else begin
                  rem_d   = bus.pkt_len;
                  idx_d   = '0;
                  state_d = FETCH;
`ifdef UCTL_TX_UNDERRUN_ABORT_EN
                  stall_d = '0;
`endif
               end
            end
         end

         FETCH: begin
            if (!bus.fifo_empty) begin
               bus.fifo_rdEn = 1'b1;
               word_d        = bus.fifo_dataOut;
               state_d       = SEND;
`ifdef UCTL_TX_UNDERRUN_ABORT_EN
               stall_d       = '0;
`endif
            end else begin
`ifdef UCTL_TX_UNDERRUN_ABORT_EN
               // Abort fires in the UNDERRUN_TO-th consecutive empty cycle.
               if (stall_q == STALL_LAST) begin
                  bus.tx_abort = 1'b1;
                  state_d      = IDLE;
                  stall_d      = '0;
               end else begin
                  stall_d = stall_q + STALL_ONE;
               end
`endif
            end
         end

         SEND: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = word_q[{idx_q, 3'b000} +: 8];
            bus.tx_last  = (rem_q == REM_ONE);
            if (bus.tx_ready) begin
               rem_d = rem_q - REM_ONE;
               idx_d = idx_q + 2'd1;
               if (rem_q == REM_ONE) begin
                  state_d = DONE;
               end else if (idx_q == 2'd3) begin
                  state_d = FETCH;
               end
            end
         end

         DONE: begin
            bus.pkt_done = 1'b1;
            state_d      = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // Soft reset wins; the pop is suppressed so no FIFO word is lost.
      if (sw_rst) begin
         state_d       = IDLE;
         rem_d         = '0;
         idx_d         = '0;
         word_d        = '0;
         zlp_d         = 1'b0;
         bus.fifo_rdEn = 1'b0;
`ifdef UCTL_TX_UNDERRUN_ABORT_EN
         stall_d       = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         zlp_q   <= 1'b0;
`ifdef UCTL_TX_UNDERRUN_ABORT_EN
         stall_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         zlp_q   <= zlp_d;
`ifdef UCTL_TX_UNDERRUN_ABORT_EN
         stall_q <= stall_d;
`endif
      end
   end

endmodule

// File: tb/tb_uctl_tx_pkt_drain.sv
// ---------------------------------------------------------------------------
// tb_uctl_tx_pkt_drain
//   Self-checking bench for uctl_tx_pkt_drain. The bench models the FIFO as a
//   queue of words and derives expected bytes directly from packet length and
//   word contents (byte i = bits [8*(i%4)+:8] of word i/4).
//   Define UCTL_TX_UNDERRUN_ABORT_EN to also exercise the underrun abort.
// ---------------------------------------------------------------------------
module tb_uctl_tx_pkt_drain;
   localparam int ADD_WIDTH   = 4;
   localparam int LEN_WIDTH   = 11;
   localparam int UNDERRUN_TO = 16;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic sw_rst = 1'b0;

   always #5 clk = ~clk;

   uctl_tx_pkt_drain_if #(.ADD_WIDTH(ADD_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

   uctl_tx_pkt_drain #(
      .ADD_WIDTH  (ADD_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH),
      .UNDERRUN_TO(UNDERRUN_TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw_rst(sw_rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // FIFO model and delayed-write schedule
   logic [31:0] fq[$];
   logic [31:0] pend_word;
   int          pend_cyc = -1;
   int          cyc = 0;
   int          rdy_mode = 0; // 0: always ready, 1: toggle, 2: random, 3: never

   // Observations gathered per cycle
   logic [7:0] got[$];
   int         last_pos[$];
   int pops, rd_bad, stall_bad, stall_seen, done_cnt, zlp_cnt, abort_cnt, busy_cnt;
   int first_valid_cyc, done_cyc, zlp_cyc, abort_cyc, last_hs_cyc;
   logic       prev_stalled;
   logic [7:0] prev_data;
   logic       prev_last;
   logic       obs_busy, obs_done;

   function automatic logic [7:0] exp_byte(input logic [31:0] w[$], input int i);
      logic [31:0] word;
      word = w[i / 4];
      return 8'(word >> (8 * (i % 4)));
   endfunction

   task automatic clear_obs();
      got.delete(); last_pos.delete();
      pops = 0; rd_bad = 0; stall_bad = 0; stall_seen = 0; done_cnt = 0;
      zlp_cnt = 0; abort_cnt = 0; busy_cnt = 0;
      first_valid_cyc = -1; done_cyc = -1; zlp_cyc = -1; abort_cyc = -1; last_hs_cyc = -1;
      prev_stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
   endtask

   // One clock cycle: present FIFO/ready inputs, sample outputs mid-cycle,
   // update the models, then advance to 1 time unit after the rising edge.
   task automatic step();
      int lvl;
      if (pend_cyc == cyc) begin
         fq.push_back(pend_word);
         pend_cyc = -1;
      end
      lvl = (fq.size() > 16) ? 16 : fq.size();
      bus.fifo_empty     = (fq.size() == 0);
      bus.fifo_dataOut   = (fq.size() == 0) ? $urandom() : fq[0];
      bus.fifo_numOfData = (ADD_WIDTH+1)'(lvl);
      case (rdy_mode)
         0:       bus.tx_ready = 1'b1;
         1:       bus.tx_ready = (cyc % 2 == 0);
         2:       bus.tx_ready = ($urandom_range(0, 3) != 0);
         default: bus.tx_ready = 1'b0;
      endcase
      #3;
      if (bus.fifo_rdEn) begin
         if (fq.size() == 0) rd_bad++;
         else begin
            void'(fq.pop_front());
            pops++;
         end
      end
      if (prev_stalled) begin
         stall_seen++;
         if (!(bus.tx_valid && bus.tx_data == prev_data && bus.tx_last == prev_last)) stall_bad++;
      end
      prev_stalled = bus.tx_valid && !bus.tx_ready;
      prev_data    = bus.tx_data;
      prev_last    = bus.tx_last;
      if (bus.tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.tx_valid && bus.tx_ready) begin
         if (bus.tx_last) last_pos.push_back(got.size());
         got.push_back(bus.tx_data);
         last_hs_cyc = cyc;
      end
      if (bus.pkt_done) begin done_cnt++;  done_cyc  = cyc; end
      if (bus.tx_zlp)   begin zlp_cnt++;   zlp_cyc   = cyc; end
      if (bus.tx_abort) begin abort_cnt++; abort_cyc = cyc; end
      if (bus.busy) busy_cnt++;
      obs_busy = bus.busy;
      obs_done = bus.pkt_done;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Issue a packet command and run until pkt_done, tx_zlp or tx_abort.
   task automatic run_pkt(input int len, input int budget, input bit spurious,
                          output int start_cyc, output bit timed_out);
      bus.pkt_start = 1'b1;
      bus.pkt_len   = LEN_WIDTH'(len);
      start_cyc     = cyc;
      step();
      bus.pkt_start = 1'b0;
      timed_out     = 1'b1;
      for (int i = 0; i < budget; i++) begin
         // A second command while a packet is in flight must be ignored.
         if (spurious && obs_busy && !obs_done && $urandom_range(0, 3) == 0) begin
            bus.pkt_start = 1'b1;
            bus.pkt_len   = LEN_WIDTH'($urandom_range(1, 1024));
         end else begin
            bus.pkt_start = 1'b0;
            bus.pkt_len   = LEN_WIDTH'($urandom());
         end
         step();
         if (done_cnt > 0 || zlp_cnt > 0 || abort_cnt > 0) begin
            timed_out = 1'b0;
            break;
         end
      end
      bus.pkt_start = 1'b0;
   endtask

   task automatic test_reset();
      fq.delete();
      fq.push_back(32'h12345678);
      clear_obs();
      rst_n = 1'b0;
      repeat (3) step();
      n_checks++;
      if ({bus.fifo_rdEn, bus.tx_valid, bus.tx_data, bus.tx_last, bus.tx_zlp,
           bus.pkt_done, bus.busy, bus.tx_abort} !== 15'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdEn=%b valid=%b data=%02h last=%b zlp=%b done=%b busy=%b abort=%b, want all 0",
                  bus.fifo_rdEn, bus.tx_valid, bus.tx_data, bus.tx_last, bus.tx_zlp,
                  bus.pkt_done, bus.busy, bus.tx_abort);
      end
      rst_n = 1'b1;
      repeat (3) step();
      n_checks++;
      if (pops !== 0 || busy_cnt !== 0 || got.size() !== 0) begin
         n_fail++;
         $display("FAIL reset_idle: pops=%0d busy_cycles=%0d bytes=%0d, want 0/0/0", pops, busy_cnt, got.size());
      end
      fq.delete();
   endtask

   task automatic test_basic8();
      logic [31:0] w[$];
      int s, bad;
      bit to;
      w = '{32'h44332211, 32'h88776655};
      fq = '{32'h44332211, 32'h88776655, 32'hCAFEF00D};
      clear_obs();
      rdy_mode = 0;
      run_pkt(8, 100, 1'b0, s, to);
      bad = -1;
      for (int i = 0; i < got.size() && i < 8; i++) if (bad < 0 && got[i] !== exp_byte(w, i)) bad = i;
      n_checks++;
      if (to || got.size() !== 8 || bad >= 0) begin
         n_fail++;
         $display("FAIL basic8_bytes: timeout=%0d bytes=%0d first_bad_idx=%0d, want 0/8/-1", to, got.size(), bad);
      end
      n_checks++;
      if (last_pos.size() !== 1 || last_pos[0] !== 7) begin
         n_fail++;
         $display("FAIL basic8_last: last_count=%0d, want single tx_last on byte 7", last_pos.size());
      end
      n_checks++;
      if (pops !== 2 || fq.size() !== 1) begin
         n_fail++;
         $display("FAIL basic8_pops: pops=%0d left=%0d, want 2/1", pops, fq.size());
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc - last_hs_cyc !== 1) begin
         n_fail++;
         $display("FAIL basic8_done: done_count=%0d done_after_last=%0d, want 1/1", done_cnt, done_cyc - last_hs_cyc);
      end
      n_checks++;
      if (first_valid_cyc - s !== 2 || done_cyc - s !== 11) begin
         n_fail++;
         $display("FAIL basic8_timing: first_valid=%0d done=%0d cycles after start, want 2/11",
                  first_valid_cyc - s, done_cyc - s);
      end
      step();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.pkt_done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic8_idle: busy=%b done=%b after packet, want 0/0", bus.busy, bus.pkt_done);
      end
      fq.delete();
   endtask

   task automatic test_partial5();
      logic [31:0] w[$];
      int s, bad;
      bit to;
      w  = '{32'hDDCCBBAA, 32'h000000EE};
      fq = '{32'hDDCCBBAA, 32'h000000EE};
      clear_obs();
      rdy_mode = 0;
      run_pkt(5, 100, 1'b0, s, to);
      bad = -1;
      for (int i = 0; i < got.size() && i < 5; i++) if (bad < 0 && got[i] !== exp_byte(w, i)) bad = i;
      n_checks++;
      if (to || got.size() !== 5 || bad >= 0) begin
         n_fail++;
         $display("FAIL partial5_bytes: timeout=%0d bytes=%0d first_bad_idx=%0d, want 0/5/-1", to, got.size(), bad);
      end
      n_checks++;
      if (last_pos.size() !== 1 || last_pos[0] !== 4 || pops !== 2 || fq.size() !== 0) begin
         n_fail++;
         $display("FAIL partial5_tail: last_count=%0d pops=%0d left=%0d, want 1 (on byte 4)/2/0",
                  last_pos.size(), pops, fq.size());
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc - s !== 8) begin
         n_fail++;
         $display("FAIL partial5_done: done_count=%0d done_at=%0d, want 1/8", done_cnt, done_cyc - s);
      end
   endtask

   task automatic test_zlp();
      int s;
      bit to;
      fq = '{32'h01020304};
      clear_obs();
      run_pkt(0, 20, 1'b0, s, to);
      repeat (4) step();
      n_checks++;
      if (to || zlp_cnt !== 1 || zlp_cyc - s !== 1) begin
         n_fail++;
         $display("FAIL zlp_pulse: timeout=%0d pulses=%0d at=%0d, want 0/1/1", to, zlp_cnt, zlp_cyc - s);
      end
      n_checks++;
      if (pops !== 0 || busy_cnt !== 0 || done_cnt !== 0 || got.size() !== 0) begin
         n_fail++;
         $display("FAIL zlp_quiet: pops=%0d busy_cycles=%0d done=%0d bytes=%0d, want all 0",
                  pops, busy_cnt, done_cnt, got.size());
      end
      fq.delete();
   endtask

   task automatic test_backpressure();
      logic [31:0] w[$];
      int s, bad;
      bit to;
      w  = '{$urandom()};
      fq = '{w[0], 32'hA5A5A5A5};
      clear_obs();
      rdy_mode = 1;
      run_pkt(4, 100, 1'b0, s, to);
      bad = -1;
      for (int i = 0; i < got.size() && i < 4; i++) if (bad < 0 && got[i] !== exp_byte(w, i)) bad = i;
      n_checks++;
      if (to || got.size() !== 4 || bad >= 0) begin
         n_fail++;
         $display("FAIL bp_bytes: timeout=%0d bytes=%0d first_bad_idx=%0d, want 0/4/-1", to, got.size(), bad);
      end
      n_checks++;
      if (stall_seen == 0 || stall_bad !== 0) begin
         n_fail++;
         $display("FAIL bp_stable: stalls=%0d unstable=%0d, want >0/0", stall_seen, stall_bad);
      end
      n_checks++;
      if (last_pos.size() !== 1 || last_pos[0] !== 3 || pops !== 1 || fq.size() !== 1 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL bp_tail: last_count=%0d pops=%0d left=%0d done=%0d, want 1/1/1/1",
                  last_pos.size(), pops, fq.size(), done_cnt);
      end
      rdy_mode = 0;
      fq.delete();
   endtask

   task automatic test_underrun();
      logic [31:0] w[$];
      int s, bad, vis;
      bit to;
      fq.delete();
      clear_obs();
      rdy_mode = 0;
      w = '{$urandom()};
      pend_word = w[0];
      vis = cyc + 11;            // ten empty FETCH cycles, then data visible
      pend_cyc = vis;
      run_pkt(3, 100, 1'b0, s, to);
      bad = -1;
      for (int i = 0; i < got.size() && i < 3; i++) if (bad < 0 && got[i] !== exp_byte(w, i)) bad = i;
      n_checks++;
      if (to || got.size() !== 3 || bad >= 0 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL underrun_bytes: timeout=%0d bytes=%0d first_bad_idx=%0d done=%0d, want 0/3/-1/1",
                  to, got.size(), bad, done_cnt);
      end
      n_checks++;
      if (rd_bad !== 0 || pops !== 1 || first_valid_cyc - vis !== 1 || abort_cnt !== 0) begin
         n_fail++;
         $display("FAIL underrun_wait: rd_while_empty=%0d pops=%0d first_valid_after_data=%0d abort=%0d, want 0/1/1/0",
                  rd_bad, pops, first_valid_cyc - vis, abort_cnt);
      end
`ifdef UCTL_TX_UNDERRUN_ABORT_EN
      fq.delete();
      clear_obs();
      pend_word = $urandom();
      pend_cyc  = cyc + 21;
      run_pkt(4, 100, 1'b0, s, to);
      repeat (8) step();
      n_checks++;
      if (to || abort_cnt !== 1 || abort_cyc - s !== UNDERRUN_TO) begin
         n_fail++;
         $display("FAIL abort_pulse: timeout=%0d pulses=%0d at=%0d, want 0/1/%0d",
                  to, abort_cnt, abort_cyc - s, UNDERRUN_TO);
      end
      n_checks++;
      if (done_cnt !== 0 || got.size() !== 0 || pops !== 0 || fq.size() !== 1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_clean: done=%0d bytes=%0d pops=%0d left=%0d busy=%b, want 0/0/0/1/0",
                  done_cnt, got.size(), pops, fq.size(), bus.busy);
      end
`endif
      fq.delete();
   endtask

   task automatic test_sw_rst();
      logic [31:0] w[$];
      int s, bad, guard;
      bit to;
      fq = '{32'h44332211, 32'h88776655, 32'h0BADBEEF};
      clear_obs();
      rdy_mode = 0;
      bus.pkt_start = 1'b1;
      bus.pkt_len   = LEN_WIDTH'(8);
      step();
      bus.pkt_start = 1'b0;
      guard = 0;
      while (got.size() < 2 && guard < 20) begin
         step();
         guard++;
      end
      sw_rst   = 1'b1;
      rdy_mode = 3;
      step();
      sw_rst   = 1'b0;
      n_checks++;
      if ({bus.fifo_rdEn, bus.tx_valid, bus.tx_data, bus.tx_last, bus.tx_zlp,
           bus.pkt_done, bus.busy, bus.tx_abort} !== 15'h0) begin
         n_fail++;
         $display("FAIL swrst_outputs: rdEn=%b valid=%b data=%02h last=%b done=%b busy=%b, want all 0",
                  bus.fifo_rdEn, bus.tx_valid, bus.tx_data, bus.tx_last, bus.pkt_done, bus.busy);
      end
      rdy_mode = 0;
      repeat (4) step();
      n_checks++;
      if (guard >= 20 || got.size() !== 2 || done_cnt !== 0 || pops !== 1) begin
         n_fail++;
         $display("FAIL swrst_abort: guard=%0d bytes=%0d done=%0d pops=%0d, want <20/2/0/1",
                  guard, got.size(), done_cnt, pops);
      end
      fq.delete();
      w  = '{$urandom(), $urandom()};
      fq = '{w[0], w[1]};
      clear_obs();
      run_pkt(6, 100, 1'b0, s, to);
      bad = -1;
      for (int i = 0; i < got.size() && i < 6; i++) if (bad < 0 && got[i] !== exp_byte(w, i)) bad = i;
      n_checks++;
      if (to || got.size() !== 6 || bad >= 0 || done_cnt !== 1 || pops !== 2) begin
         n_fail++;
         $display("FAIL swrst_restart: timeout=%0d bytes=%0d first_bad_idx=%0d done=%0d pops=%0d, want 0/6/-1/1/2",
                  to, got.size(), bad, done_cnt, pops);
      end
      fq.delete();
   endtask

   task automatic test_random();
      logic [31:0] w[$];
      int s, bad, len, nw;
      bit to;
      rdy_mode = 2;
      for (int p = 0; p < 25; p++) begin
         len = (p == 0) ? 1024 : $urandom_range(1, 64);
         nw  = (len + 3) / 4;
         w.delete();
         fq.delete();
         for (int k = 0; k < nw; k++) w.push_back($urandom());
         foreach (w[k]) fq.push_back(w[k]);
         fq.push_back(32'hFEEDFACE);
         clear_obs();
         run_pkt(len, 4000, 1'b1, s, to);
         bad = -1;
         for (int i = 0; i < got.size() && i < len; i++) if (bad < 0 && got[i] !== exp_byte(w, i)) bad = i;
         n_checks++;
         if (to || got.size() !== len || bad >= 0) begin
            n_fail++;
            $display("FAIL rand_bytes[%0d]: len=%0d timeout=%0d bytes=%0d first_bad_idx=%0d",
                     p, len, to, got.size(), bad);
         end
         n_checks++;
         if (last_pos.size() !== 1 || last_pos[0] !== len - 1 || pops !== nw || fq.size() !== 1 ||
             done_cnt !== 1 || stall_bad !== 0 || rd_bad !== 0) begin
            n_fail++;
            $display("FAIL rand_ctrl[%0d]: len=%0d last_count=%0d pops=%0d (want %0d) left=%0d done=%0d unstable=%0d",
                     p, len, last_pos.size(), pops, nw, fq.size(), done_cnt, stall_bad);
         end
      end
      rdy_mode = 0;
      fq.delete();
   endtask

   initial begin
      bus.pkt_start      = 1'b0;
      bus.pkt_len        = '0;
      bus.fifo_empty     = 1'b1;
      bus.fifo_dataOut   = '0;
      bus.fifo_numOfData = '0;
      bus.tx_ready       = 1'b0;
      test_reset();
      test_basic8();
      test_partial5();
      test_zlp();
      test_backpressure();
      test_underrun();
      test_sw_rst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
